// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the BCD-to-binary converter: digit input side and
// binary result side, each with its own valid/ready pair.
interface bcd_to_bin_if #(
    parameter int NDIG  = 5,
    parameter int OUT_W = 17
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4*NDIG-1:0]    bcd_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     bin_out;
    logic                 ovf16;
    logic                 err;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, ovf16, err
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, ovf16, err
    );
endinterface

// File: rtl/bcd_to_bin.sv
// Digit-serial BCD-to-binary converter: accumulates acc*10 + digit one digit
// per cycle, most significant digit first, with valid/ready on both sides.
module bcd_to_bin #(
    parameter int NDIG  = 5,
    parameter int OUT_W = 17
) (
    input  logic       clk,
    input  logic       rst,
    bcd_to_bin_if.slave bus
);
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t               state;
    logic [4*NDIG-1:0]    dig;
    logic [OUT_W-1:0]     acc;
    logic [CNT_W-1:0]     cnt;
    logic                 err_r;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [OUT_W-1:0]     bin_q;
    logic                 ovf_q;
    logic                 err_q;
    logic [OUT_W-1:0]     acc_next;

    // acc*10 built from shifts in a 4-bit wider field, then truncated back.
    function automatic logic [OUT_W-1:0] mul10_add(input logic [OUT_W-1:0] a,
                                                   input logic [3:0] d);
        logic [OUT_W+3:0] aw;
        aw = {4'b0000, a};
        return OUT_W'((aw << 3) + (aw << 1) + (OUT_W+4)'(d));
    endfunction

    function automatic logic any_bad_nibble(input logic [4*NDIG-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // The digit register shifts left each cycle so the current digit is always on top.
    assign acc_next = mul10_add(acc, dig[4*NDIG-1 -: 4]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            dig         <= '0;
            acc         <= '0;
            cnt         <= '0;
            err_r       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bin_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        dig        <= bus.bcd_in;
                        acc        <= '0;
                        cnt        <= '0;
                        err_r      <= any_bad_nibble(bus.bcd_in);
                        in_ready_q <= 1'b0;
                        state      <= CONV;
                    end
                end
                CONV: begin
                    acc <= acc_next;
                    dig <= dig << 4;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(NDIG - 1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        bin_q       <= err_r ? '0 : acc_next;
                        ovf_q       <= !err_r && (acc_next > OUT_W'(32'h0000_FFFF));
                        err_q       <= err_r;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bin_out   = bin_q;
    assign bus.ovf16     = ovf_q;
    assign bus.err       = err_q;
endmodule
